// File: rtl/crumb_display_reader.sv
// rtl/crumb_display_reader.sv - captures the crumb display chain and streams it out as packed words
module crumb_display_reader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              display,
  output logic              chain_shift,
  input  logic              chain_in,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              done
);

  localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
  localparam int BIT_W     = $clog2(WORD_W);
  localparam int WCNT_W    = $clog2(NUM_WORDS) + 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WCNT_W-1:0]   word_cnt;
  logic [WORD_W-1:0]   shift_buf;
  logic [WORD_W-1:0]   buf_nxt;
  logic                handshake;

  assign handshake = word_valid && word_ready;

  // Shift buffer with the current chain bit dropped into its slot, so a
  // completed word can be published in the same edge as its last bit.
  always_comb begin
    buf_nxt          = shift_buf;
    buf_nxt[bit_cnt] = chain_in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt   = state;
    display     = 1'b0;
    chain_shift = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        display   = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        chain_shift = 1'b1;
        if (bit_cnt == BIT_LAST) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Chain is frozen here so a stalled consumer never loses bits.
        if (handshake) state_nxt = word_last ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit packing, word hand-off and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shift_buf  <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      case (state)
        S_CAPTURE: begin
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
        S_SHIFT: begin
          shift_buf <= buf_nxt;
          if (bit_cnt == BIT_LAST) begin
            word_data  <= buf_nxt;
            word_valid <= 1'b1;
            word_last  <= (word_cnt == WORD_LAST);
            bit_cnt    <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            word_cnt   <= word_cnt + 1'b1;
          end
        end
        S_DONE: begin
          word_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crumb_display_reader.sv
// tb/tb_crumb_display_reader.sv - scoreboard bench for crumb_display_reader
module tb_crumb_display_reader;

  localparam int CHAIN_LEN = 16;
  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = CHAIN_LEN / WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              display;
  logic              chain_shift;
  logic              chain_in;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [CHAIN_LEN-1:0] chain_q = '0;
  logic [CHAIN_LEN-1:0] cap_pattern = '0;
  logic [WORD_W:0]      exp_q[$];

  int cyc = 0;
  int start_cyc = 0;
  int first_rise = -1;
  int done_cyc = -1;
  int shift_cnt = 0;
  int disp_cnt = 0;
  int done_cnt = 0;
  int frame_words = 0;
  logic prev_valid = 1'b0;

  crumb_display_reader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .display    (display),
    .chain_shift(chain_shift),
    .chain_in   (chain_in),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Display chain model: parallel load on display, shift toward the reader.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (display)          chain_q <= cap_pattern;
    else if (chain_shift) chain_q <= chain_q >> 1;
  end
  assign chain_in = chain_q[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: event counters and scoreboard pops on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (chain_shift) shift_cnt++;
      if (display)     disp_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (word_valid && !prev_valid && frame_words == 0) first_rise = cyc;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          logic [WORD_W:0] e;
          e = exp_q.pop_front();
          check("word_data", 32'(word_data), 32'(e[WORD_W-1:0]));
          check("word_last", 32'(word_last), 32'(e[WORD_W]));
        end
        frame_words++;
      end
      prev_valid = word_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CHAIN_LEN-1:0] p);
    cap_pattern = p;
    for (int w = 0; w < NUM_WORDS; w++)
      exp_q.push_back({(w == NUM_WORDS - 1), p[w*WORD_W +: WORD_W]});
    shift_cnt   = 0;
    disp_cnt    = 0;
    frame_words = 0;
    first_rise  = -1;
    start_cyc   = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ready);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 1000) begin
      if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
    word_ready = 1'b1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!word_valid && n < 100) begin
      tick();
      n++;
    end
    if (!word_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    word_ready = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", 32'({busy, display, chain_shift, word_valid, word_last, done}), 32'd0);
    check("reset_data", 32'(word_data), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame with latency checks.
    do_start(16'h3CA5);
    wait_done(1'b0);
    check("basic_shifts", 32'(shift_cnt), 32'(CHAIN_LEN));
    check("basic_display", 32'(disp_cnt), 32'd1);
    check("basic_first_valid", 32'(first_rise - start_cyc), 32'(WORD_W + 2));
    check("basic_done_lat", 32'(done_cyc - start_cyc + 1), 32'(CHAIN_LEN + NUM_WORDS + 3));
    check("basic_words", 32'(frame_words), 32'(NUM_WORDS));
    check("basic_busy_after", 32'(busy), 32'd0);

    // Backpressure on the first word.
    word_ready = 1'b0;
    do_start(16'h3CA5);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(word_data), 32'hA5);
      check("bp_no_shift", 32'(chain_shift), 32'd0);
      check("bp_valid", 32'(word_valid), 32'd1);
      tick();
    end
    word_ready = 1'b1;
    wait_done(1'b0);
    check("bp_shifts", 32'(shift_cnt), 32'(CHAIN_LEN));
    check("bp_words", 32'(frame_words), 32'(NUM_WORDS));

    // Start pulsed while busy is ignored.
    d0 = done_cnt;
    do_start(16'h0F96);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    repeat (3) tick();
    check("busy_start_display", 32'(disp_cnt), 32'd1);
    check("busy_start_words", 32'(frame_words), 32'(NUM_WORDS));
    check("busy_start_dones", 32'(done_cnt - d0), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Back-to-back: start in the cycle right after done.
    do_start(16'h3CA5);
    wait_done(1'b0);
    do_start(16'hFFFF);
    wait_done(1'b0);
    check("b2b_display", 32'(disp_cnt), 32'd1);
    check("b2b_words", 32'(frame_words), 32'(NUM_WORDS));
    check("b2b_done_lat", 32'(done_cyc - start_cyc + 1), 32'(CHAIN_LEN + NUM_WORDS + 3));

    // Reset mid-SHIFT aborts the frame, then a fresh frame is intact.
    do_start(16'h1234);
    repeat (4) tick();
    check("pre_reset_shift", 32'(chain_shift), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_reset_ctrl", 32'({busy, display, chain_shift, word_valid, word_last, done}), 32'd0);
    check("mid_reset_data", 32'(word_data), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    do_start(16'h5AC3);
    wait_done(1'b0);
    check("post_reset_words", 32'(frame_words), 32'(NUM_WORDS));
    check("post_reset_shifts", 32'(shift_cnt), 32'(CHAIN_LEN));

    // Random ready over 8 random frames.
    for (int f = 0; f < 8; f++) begin
      do_start(CHAIN_LEN'($urandom));
      wait_done(1'b1);
      check("rand_words", 32'(frame_words), 32'(NUM_WORDS));
      check("rand_shifts", 32'(shift_cnt), 32'(CHAIN_LEN));
      check("rand_display", 32'(disp_cnt), 32'd1);
    end
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
